// File: rtl/vga_pattern_gen.sv
// Pixel source for the vga timing core: selectable test patterns with frame-synchronous config.
// Latency: pixel is registered, one cycle after hcount/vcount.
// Backpressure: none; a cfg_valid strobe is always accepted, and the last write before frame start wins.
module vga_pattern_gen #(
    parameter int HSYNC_BITS = 11,
    parameter int VSYNC_BITS = 11,
    parameter int HD         = 1280,
    parameter int VD         = 1024,
    parameter int COLOR_BITS = 12,
    parameter int BAR_SHIFT  = 7,
    parameter int CHK_SHIFT  = 5,
    parameter int FRAME_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HSYNC_BITS-1:0] hcount,
    input  logic [VSYNC_BITS-1:0] vcount,
    input  logic                  cfg_valid,
    input  logic [2:0]            cfg_mode,
    input  logic [VSYNC_BITS-1:0] cfg_row,
    input  logic [COLOR_BITS-1:0] cfg_fg,
    input  logic [COLOR_BITS-1:0] cfg_bg,
    output logic                  cfg_pending,
    output logic [COLOR_BITS-1:0] pixel,
    output logic [FRAME_BITS-1:0] frame_cnt
);

    localparam int CB = COLOR_BITS / 3;
    localparam logic [HSYNC_BITS-1:0] HD_W     = HSYNC_BITS'(HD);
    localparam logic [VSYNC_BITS-1:0] VD_W     = VSYNC_BITS'(VD);
    localparam logic [VSYNC_BITS-1:0] ROW_DFLT = VSYNC_BITS'(VD - 24);
    localparam logic [VSYNC_BITS-1:0] ROW_LAST = VSYNC_BITS'(VD - 1);

    typedef enum logic [2:0] {
        M_SOLID   = 3'd0,
        M_HLINE   = 3'd1,
        M_BARS    = 3'd2,
        M_CHECKER = 3'd3,
        M_SCROLL  = 3'd4
    } mode_t;

    logic [2:0]            pend_mode, act_mode;
    logic [VSYNC_BITS-1:0] pend_row,  act_row, scroll_row;
    logic [COLOR_BITS-1:0] pend_fg,   act_fg;
    logic [COLOR_BITS-1:0] pend_bg,   act_bg;

    logic                  fs;
    logic                  blank;
    logic [2:0]            bar_idx;
    logic                  chk_bit;
    logic [COLOR_BITS-1:0] pix_nxt;

    assign fs    = (hcount == '0) && (vcount == '0);
    assign blank = (hcount >= HD_W) || (vcount >= VD_W);

    // Shifts are done at full input width, then only the low bits are kept.
    assign bar_idx = 3'(hcount >> BAR_SHIFT);
    assign chk_bit = 1'(hcount >> CHK_SHIFT) ^ 1'(vcount >> CHK_SHIFT);

    always_comb begin
        pix_nxt = act_bg;
        case (act_mode)
            M_SOLID:   pix_nxt = act_bg;
            M_HLINE:   if (vcount == act_row) pix_nxt = act_fg;
            M_BARS:    pix_nxt = {{CB{bar_idx[2]}}, {CB{bar_idx[1]}}, {CB{bar_idx[0]}}};
            M_CHECKER: if (chk_bit) pix_nxt = act_fg;
            M_SCROLL:  if (vcount == scroll_row) pix_nxt = act_fg;
            default:   pix_nxt = act_bg;
        endcase
        if (blank) pix_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel       <= '0;
            frame_cnt   <= '0;
            cfg_pending <= 1'b0;
            act_mode    <= M_HLINE;
            act_row     <= ROW_DFLT;
            act_fg      <= '1;
            act_bg      <= '0;
            scroll_row  <= ROW_DFLT;
            pend_mode   <= M_SOLID;
            pend_row    <= '0;
            pend_fg     <= '0;
            pend_bg     <= '0;
        end else begin
            pixel <= pix_nxt;

            if (fs) begin
                frame_cnt <= frame_cnt + FRAME_BITS'(1);
                if (cfg_pending) begin
                    act_mode    <= pend_mode;
                    act_row     <= pend_row;
                    act_fg      <= pend_fg;
                    act_bg      <= pend_bg;
                    scroll_row  <= pend_row;
                    cfg_pending <= 1'b0;
                end else if (scroll_row == ROW_LAST) begin
                    scroll_row <= '0;
                end else begin
                    scroll_row <= scroll_row + VSYNC_BITS'(1);
                end
            end

            // A strobe on the apply edge refills the pending set after the old one is consumed.
            if (cfg_valid) begin
                pend_mode   <= cfg_mode;
                pend_row    <= cfg_row;
                pend_fg     <= cfg_fg;
                pend_bg     <= cfg_bg;
                cfg_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: counters are driven directly so frames can be jumped.
module tb_vga_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        cfg_valid;
    logic [2:0]  cfg_mode;
    logic [10:0] cfg_row;
    logic [11:0] cfg_fg;
    logic [11:0] cfg_bg;
    logic        cfg_pending;
    logic [11:0] pixel;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    vga_pattern_gen dut (
        .clk         (clk),
        .rst         (rst),
        .hcount      (hcount),
        .vcount      (vcount),
        .cfg_valid   (cfg_valid),
        .cfg_mode    (cfg_mode),
        .cfg_row     (cfg_row),
        .cfg_fg      (cfg_fg),
        .cfg_bg      (cfg_bg),
        .cfg_pending (cfg_pending),
        .pixel       (pixel),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive counters, take one rising edge, land 1 time unit after it.
    task automatic step(input logic [10:0] h, input logic [10:0] v);
        hcount = h;
        vcount = v;
        @(posedge clk);
        #1;
    endtask

    task automatic px(input logic [10:0] h, input logic [10:0] v, input logic [11:0] exp, input string tag);
        step(h, v);
        chk(tag, {20'd0, pixel}, {20'd0, exp});
    endtask

    task automatic strobe(input logic [10:0] h, input logic [10:0] v, input logic [2:0] m,
                          input logic [10:0] r, input logic [11:0] fg, input logic [11:0] bg);
        cfg_valid = 1'b1;
        cfg_mode  = m;
        cfg_row   = r;
        cfg_fg    = fg;
        cfg_bg    = bg;
        step(h, v);
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_mode = 3'd0; cfg_row = '0; cfg_fg = '0; cfg_bg = '0;
        hcount = 11'd5; vcount = 11'd5;
        step(11'd5, 11'd5);
        step(11'd5, 11'd5);
        chk("rst_pixel", {20'd0, pixel}, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("rst_pending", {31'd0, cfg_pending}, 32'd0);
        rst = 1'b0;

        // Defaults: white line on row 1000, black elsewhere and in blanking.
        px(11'd10, 11'd1000, 12'hFFF, "dflt_line");
        hcount = 11'd10; vcount = 11'd999;
        #3;
        chk("latency_hold", {20'd0, pixel}, 32'hFFF);
        @(posedge clk); #1;
        chk("latency_next", {20'd0, pixel}, 32'h000);
        px(11'd1279, 11'd1000, 12'hFFF, "dflt_line_lastcol");
        px(11'd1280, 11'd1000, 12'h000, "hblank");
        px(11'd10, 11'd1024, 12'h000, "vblank");
        px(11'd0, 11'd0, 12'h000, "dflt_fs_pixel");
        chk("fs_cnt1", {16'd0, frame_cnt}, 32'd1);

        // Mid-frame solid blue request; old pattern runs to frame end.
        strobe(11'd20, 11'd500, 3'd0, 11'd0, 12'hFFF, 12'h00F);
        chk("pend_set", {31'd0, cfg_pending}, 32'd1);
        chk("pend_px_old", {20'd0, pixel}, 32'h000);
        px(11'd20, 11'd1000, 12'hFFF, "old_pattern_continues");
        chk("pend_held", {31'd0, cfg_pending}, 32'd1);
        px(11'd0, 11'd0, 12'h000, "fs_uses_old_cfg");
        chk("pend_clear", {31'd0, cfg_pending}, 32'd0);
        chk("fs_cnt2", {16'd0, frame_cnt}, 32'd2);
        px(11'd0, 11'd1, 12'h00F, "solid_first");
        px(11'd700, 11'd800, 12'h00F, "solid_mid");
        px(11'd1300, 11'd5, 12'h000, "solid_blank");

        // Colour bars.
        strobe(11'd50, 11'd50, 3'd2, 11'd0, 12'h123, 12'h456);
        px(11'd0, 11'd0, 12'h00F, "bars_fs_old_solid");
        px(11'd0, 11'd10, 12'h000, "bar0");
        px(11'd127, 11'd10, 12'h000, "bar0_edge");
        px(11'd128, 11'd10, 12'h00F, "bar1");
        px(11'd300, 11'd10, 12'h0F0, "bar2");
        px(11'd640, 11'd10, 12'hF0F, "bar5");
        px(11'd896, 11'd10, 12'hFFF, "bar7");
        px(11'd1024, 11'd10, 12'h000, "bar_wrap");

        // Scrolling line from row 1022.
        strobe(11'd50, 11'd50, 3'd4, 11'd1022, 12'hF00, 12'h000);
        step(11'd0, 11'd0);
        chk("fs_cnt4", {16'd0, frame_cnt}, 32'd4);
        px(11'd5, 11'd1022, 12'hF00, "scroll_f1_line");
        px(11'd5, 11'd1021, 12'h000, "scroll_f1_off");
        step(11'd0, 11'd0);
        chk("fs_cnt5", {16'd0, frame_cnt}, 32'd5);
        px(11'd5, 11'd1023, 12'hF00, "scroll_f2_line");
        px(11'd5, 11'd1022, 12'h000, "scroll_f2_off");
        step(11'd0, 11'd0);
        chk("fs_cnt6", {16'd0, frame_cnt}, 32'd6);
        px(11'd5, 11'd0, 12'hF00, "scroll_f3_wrap");
        px(11'd5, 11'd1, 12'h000, "scroll_f3_off");

        // Last write wins, then a strobe on the FS cycle itself.
        strobe(11'd9, 11'd9, 3'd3, 11'd0, 12'hFFF, 12'h000);
        strobe(11'd9, 11'd10, 3'd1, 11'd5, 12'h0F0, 12'h001);
        strobe(11'd0, 11'd0, 3'd0, 11'd0, 12'h000, 12'h123);
        chk("fs_strobe_px_scroll_row0", {20'd0, pixel}, 32'hF00);
        chk("fs_strobe_pending", {31'd0, cfg_pending}, 32'd1);
        chk("fs_cnt7", {16'd0, frame_cnt}, 32'd7);
        px(11'd3, 11'd5, 12'h0F0, "lastwin_line");
        px(11'd32, 11'd0, 12'h001, "lastwin_not_checker");
        px(11'd0, 11'd0, 12'h001, "fs2_px");
        chk("fs2_pend_clear", {31'd0, cfg_pending}, 32'd0);
        px(11'd3, 11'd5, 12'h123, "fs_strobe_applied");

        // Checkerboard and a reserved mode.
        strobe(11'd9, 11'd9, 3'd3, 11'd0, 12'hFFF, 12'h000);
        step(11'd0, 11'd0);
        px(11'd32, 11'd0, 12'hFFF, "chk_10");
        px(11'd32, 11'd32, 12'h000, "chk_11");
        px(11'd0, 11'd32, 12'hFFF, "chk_01");
        px(11'd64, 11'd32, 12'hFFF, "chk_21");
        px(11'd1279, 11'd1023, 12'h000, "chk_corner");
        strobe(11'd9, 11'd9, 3'd5, 11'd0, 12'hFFF, 12'h0A0);
        step(11'd0, 11'd0);
        chk("fs_cnt10", {16'd0, frame_cnt}, 32'd10);
        px(11'd77, 11'd1000, 12'h0A0, "reserved_bg");

        // Reset mid-line with a pending config.
        strobe(11'd9, 11'd9, 3'd0, 11'd0, 12'h000, 12'h555);
        rst = 1'b1;
        step(11'd100, 11'd300);
        rst = 1'b0;
        chk("rst2_pixel", {20'd0, pixel}, 32'd0);
        chk("rst2_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("rst2_pending", {31'd0, cfg_pending}, 32'd0);
        px(11'd0, 11'd0, 12'h000, "rst2_fs_px");
        chk("rst2_cnt1", {16'd0, frame_cnt}, 32'd1);
        px(11'd7, 11'd1000, 12'hFFF, "rst2_default_line");
        px(11'd7, 11'd999, 12'h000, "rst2_default_off");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Parametrised pixel source; drives the colour input of the `vga` timing core from that core's `hcount`/`vcount`.
- Successor to the fixed single-line generator. Adds:
  - runtime-selectable test patterns (solid, horizontal line, colour bars, checkerboard, scrolling line)
  - configurable foreground and background colours
  - frame-synchronous configuration update
  - a frame counter
- Output is registered and lands one cycle after `hcount`/`vcount`.

Parameters:
- HSYNC_BITS, 11, width of `hcount`.
- VSYNC_BITS, 11, width of `vcount`.
- HD, 1280, visible pixels per line.
- VD, 1024, visible lines per frame.
- COLOR_BITS, 12, pixel width; R:G:B equal thirds, R in the MSBs; must be divisible by 3.
- BAR_SHIFT, 7, log2 of colour-bar width in pixels.
- CHK_SHIFT, 5, log2 of checker square size in pixels.
- FRAME_BITS, 16, width of `frame_cnt`.

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  synchronous reset, active-high
- hcount  in  HSYNC_BITS  current column from timing core
- vcount  in  VSYNC_BITS  current row from timing core
- cfg_valid  in  1  one-cycle strobe; capture `cfg_*` into the pending set
- cfg_mode  in  3  pattern select
- cfg_row  in  VSYNC_BITS  line row for HLINE, start row for SCROLL
- cfg_fg  in  COLOR_BITS  foreground colour
- cfg_bg  in  COLOR_BITS  background colour
- cfg_pending  out  1  pending config not yet applied
- pixel  out  COLOR_BITS  colour to timing core
- frame_cnt  out  FRAME_BITS  completed frame starts since reset

Behaviour:
- Reset: clock and reset are fixed; one clock `clk`, reset `rst` synchronous active-high. While `rst`=1 at a rising edge:
  - `pixel` = 0, `frame_cnt` = 0, `cfg_pending` = 0.
  - Active config becomes mode=1, row=VD-24, fg=all-ones, bg=0.
  - Scroll row register = VD-24.
- Reset mid-frame: pending config is discarded. Output resumes at the next edge after reset deasserts, using the defaults.
- Frame start (FS): the cycle where `hcount`==0 and `vcount`==0.
- Config capture:
  - `cfg_valid`=1 loads `cfg_*` into the pending set and sets `cfg_pending`=1.
  - A later `cfg_valid` before FS overwrites the pending set (last write wins).
- Config apply: at FS with `cfg_pending`=1, on that edge:
  - pending is copied to active and `cfg_pending` clears.
  - scroll row register loads `cfg_row`.
- Simultaneous `cfg_valid` and FS:
  - the previously pending set (if any) is applied;
  - the new values become pending and `cfg_pending` stays 1.
  - With nothing previously pending, active is unchanged and the new values wait for the next FS.
- Frame counter: `frame_cnt` increments by 1 at every FS edge and wraps to 0 after all-ones. The FS edge right after reset counts.
- Scroll row: at FS with no apply, the row advances by 1, wrapping VD-1 -> 0. It advances in every mode but is only used by SCROLL.
- Pixel pipeline: `pixel` at edge N+1 is a function of `hcount`/`vcount` and the active config at edge N. Latency is exactly 1 cycle.
- Pixels on the FS cycle use the config active before that edge. The new config takes effect from pixel (0,1) onward; this one-pixel skew is accepted.
- Blanking: `hcount`>=HD or `vcount`>=VD gives `pixel`=0 regardless of mode.
- Modes (active mode, visible area):
  - 0 SOLID: bg.
  - 1 HLINE: fg if `vcount`==row, else bg.
  - 2 BARS: idx = (`hcount`>>BAR_SHIFT) mod 8. Bit2 of idx drives R, bit1 drives G, bit0 drives B. Each set bit gives its channel all-ones; each clear bit gives 0. fg and bg are ignored.
  - 3 CHECKER: fg if bit0 of ((`hcount`>>CHK_SHIFT) XOR (`vcount`>>CHK_SHIFT)) is 1, else bg.
  - 4 SCROLL: fg if `vcount`== scroll row register, else bg.
  - 5..7 reserved: bg.
- Widths: all compares are unsigned at full input width. No truncation of `hcount`/`vcount` before the shifts.

Test Plan:
- Reset, defaults, HD=1280, VD=1024, sweep one frame -> `pixel`=12'hFFF only on row 1000, 0 elsewhere; 0 in blanking; output 1 cycle after the counters.
- `cfg_valid` mid-frame with mode=0, bg=12'h00F -> `cfg_pending`=1 until next FS; old pattern continues to frame end; next frame all 12'h00F; `cfg_pending` clears on the FS edge.
- Mode=2 -> `hcount` 0..127 gives 12'h000, 128..255 gives 12'h00F, 640..767 gives 12'hF0F, 896..1023 gives 12'hFFF, 1024..1151 gives 12'h000 (wrap).
- Mode=4, row=1022, fg=12'hF00 -> frame 1 line at 1022, frame 2 at 1023, frame 3 at 0; `frame_cnt` increments by exactly 1 per FS.
- Two `cfg_valid` strobes before FS (mode=3, then mode=1 row=5), then `cfg_valid` on the FS cycle with mode=0 -> mode=1 row=5 applied; `cfg_pending` stays 1; mode=0 applied at the following FS.
- Assert `rst` for 1 cycle mid-line with a config pending -> `pixel`=0, `frame_cnt`=0, `cfg_pending`=0 after the edge; next frame shows the default row-1000 line.
